// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns stage: accepts one 128-bit state, transforms
// COLS_PER_CYCLE columns per clock, then holds the result until it is consumed.
module inv_mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] dataIn,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dataOut,
    output logic         busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : gBadParam
            $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;

    stateT        state;
    stateT        stateNext;
    logic [2:0]   cnt;
    logic [127:0] workReg;
    logic [127:0] workNext;
    logic         lastGroup;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Each byte contributes 09/0B/0D/0E multiples built from its x2/x4/x8 chain.
    function automatic logic [31:0] invMixCol(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mB [4];
        logic [7:0] mD [4];
        logic [7:0] mE [4];
        logic [7:0] m2, m4, m8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            m2    = xtime(a[r]);
            m4    = xtime(m2);
            m8    = xtime(m4);
            m9[r] = m8 ^ a[r];
            mB[r] = m8 ^ m2 ^ a[r];
            mD[r] = m8 ^ m4 ^ a[r];
            mE[r] = m8 ^ m4 ^ m2;
        end
        return {mE[0] ^ mB[1] ^ mD[2] ^ m9[3],
                m9[0] ^ mE[1] ^ mB[2] ^ mD[3],
                mD[0] ^ m9[1] ^ mE[2] ^ mB[3],
                mB[0] ^ mD[1] ^ m9[2] ^ mE[3]};
    endfunction

    // Only the column group selected by cnt is rewritten; the rest pass through.
    always_comb begin
        workNext = workReg;
        for (int c = 0; c < 4; c++) begin
            if (3'(c) >= cnt && 3'(c) < cnt + STEP)
                workNext[127-32*c -: 32] = invMixCol(workReg[127-32*c -: 32]);
        end
    end

    assign lastGroup = (cnt + STEP == 3'd4);

    // NOTE: every output and next-state gets a default first so no latch is inferred.
    always_comb begin
        stateNext = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) stateNext = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (lastGroup) stateNext = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            workReg <= 128'h0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        workReg <= dataIn;
                        cnt     <= 3'd0;
                    end
                end
                CALC: begin
                    workReg <= workNext;
                    cnt     <= cnt + STEP;
                end
                default: ;
            endcase
        end
    end

    assign dataOut = workReg;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Directed bench for inv_mix_columns_iter: three instances (P=1,2,4) share the
// input side; the P=2/P=4 instances have their own reset so they can be parked.
module tb_inv_mix_columns_iter;

    logic         clk;
    logic         nRst;
    logic         nRstAlt;
    logic         inValid;
    logic         outReady;
    logic [127:0] dataIn;
    logic         inReady  [3];
    logic         outValid [3];
    logic         busy     [3];
    logic [127:0] dataOut  [3];

    int testsRun = 0;
    int testsFailed = 0;

    localparam logic [127:0] RT_IN    = 128'h4C9F42BCA3703AA640D4E4A5473794ED;
    localparam logic [127:0] RT_OUT   = 128'h97ECC3954D904AD8F24CE78C876E46A6;
    localparam logic [127:0] FIPS_IN  = 128'h8E4DA1BC_D5D5D7D6_4D7EBDF8_F2F2F2F2;
    localparam logic [127:0] FIPS_OUT = 128'hDB135345_D4D4D4D5_2D26314C_F2F2F2F2;
    localparam logic [127:0] FIX_VEC  = 128'h01010101_C6C6C6C6_01010101_C6C6C6C6;

    inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .n_rst(nRst), .in_valid(inValid), .in_ready(inReady[0]),
        .dataIn(dataIn), .out_valid(outValid[0]), .out_ready(outReady),
        .dataOut(dataOut[0]), .busy(busy[0]));

    inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .n_rst(nRstAlt), .in_valid(inValid), .in_ready(inReady[1]),
        .dataIn(dataIn), .out_valid(outValid[1]), .out_ready(outReady),
        .dataOut(dataOut[1]), .busy(busy[1]));

    inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .n_rst(nRstAlt), .in_valid(inValid), .in_ready(inReady[2]),
        .dataIn(dataIn), .out_valid(outValid[2]), .out_ready(outReady),
        .dataOut(dataOut[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One block through the first nDut instances with out_ready high; latency,
    // busy length, single-cycle out_valid and result are checked per instance.
    task automatic runBlock(input string tag, input logic [127:0] din,
                            input logic [127:0] exp, input int nDut);
        int           firstV [3];
        int           nV     [3];
        int           nBusy  [3];
        logic [127:0] got    [3];
        int           lat;
        dataIn   = din;
        inValid  = 1'b1;
        outReady = 1'b1;
        for (int d = 0; d < nDut; d++)
            check($sformatf("%s.inReady.p%0d", tag, 1 << d), 128'(inReady[d]), 128'(1));
        tick();
        inValid = 1'b0;
        dataIn  = ~din;
        for (int d = 0; d < nDut; d++) begin
            firstV[d] = -1;
            nV[d]     = 0;
            nBusy[d]  = busy[d] ? 1 : 0;
            got[d]    = '0;
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            for (int d = 0; d < nDut; d++) begin
                if (busy[d]) nBusy[d]++;
                if (outValid[d]) begin
                    if (firstV[d] < 0) begin
                        firstV[d] = k;
                        got[d]    = dataOut[d];
                    end
                    nV[d]++;
                end
            end
        end
        for (int d = 0; d < nDut; d++) begin
            lat = 4 / (1 << d);
            check($sformatf("%s.data.p%0d", tag, 1 << d), got[d], exp);
            check($sformatf("%s.latency.p%0d", tag, 1 << d), 128'(firstV[d]), 128'(lat));
            check($sformatf("%s.busyCycles.p%0d", tag, 1 << d), 128'(nBusy[d]), 128'(lat));
            check($sformatf("%s.validCycles.p%0d", tag, 1 << d), 128'(nV[d]), 128'(1));
        end
    endtask

    initial begin
        logic [127:0] blk    [3];
        logic [127:0] blkExp [3];
        int           accCyc [3];
        int           nAcc;
        int           nRes;
        logic         acc;

        nRst     = 1'b0;
        nRstAlt  = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        dataIn   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nRst    = 1'b1;
        nRstAlt = 1'b1;
        tick();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset.inReady.%0d", d), 128'(inReady[d]), 128'(1));
            check($sformatf("reset.outValid.%0d", d), 128'(outValid[d]), 128'(0));
            check($sformatf("reset.busy.%0d", d), 128'(busy[d]), 128'(0));
            check($sformatf("reset.dataOut.%0d", d), dataOut[d], 128'h0);
        end

        runBlock("roundtrip", RT_IN, RT_OUT, 3);
        runBlock("fips", FIPS_IN, FIPS_OUT, 3);

        // Remaining scenarios target the P=1 instance only.
        nRstAlt = 1'b0;

        // Backpressure: result held for 5 cycles while a second state waits.
        dataIn   = FIPS_IN;
        inValid  = 1'b1;
        outReady = 1'b0;
        tick();
        dataIn = FIX_VEC;
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp.outValid.%0d", i), 128'(outValid[0]), 128'(1));
            check($sformatf("bp.dataOut.%0d", i), dataOut[0], FIPS_OUT);
            check($sformatf("bp.inReady.%0d", i), 128'(inReady[0]), 128'(0));
            tick();
        end
        outReady = 1'b1;
        tick();
        check("bp.release.outValid", 128'(outValid[0]), 128'(0));
        check("bp.release.inReady", 128'(inReady[0]), 128'(1));
        check("bp.release.busy", 128'(busy[0]), 128'(0));
        tick();
        check("bp.second.busy", 128'(busy[0]), 128'(1));
        inValid = 1'b0;
        repeat (4) tick();
        check("bp.second.outValid", 128'(outValid[0]), 128'(1));
        check("bp.second.dataOut", dataOut[0], FIX_VEC);
        tick();

        // Asynchronous reset two cycles into CALC.
        dataIn  = RT_IN;
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        repeat (2) tick();
        check("midrst.busyBefore", 128'(busy[0]), 128'(1));
        #2;
        nRst = 1'b0;
        #1;
        check("midrst.busy", 128'(busy[0]), 128'(0));
        check("midrst.inReady", 128'(inReady[0]), 128'(1));
        check("midrst.outValid", 128'(outValid[0]), 128'(0));
        check("midrst.dataOut", dataOut[0], 128'h0);
        @(negedge clk);
        nRst = 1'b1;
        tick();
        runBlock("afterrst", FIX_VEC, FIX_VEC, 1);

        // Back-to-back stream with in_valid and out_ready held high.
        blk[0] = RT_IN;   blkExp[0] = RT_OUT;
        blk[1] = FIPS_IN; blkExp[1] = FIPS_OUT;
        blk[2] = FIX_VEC; blkExp[2] = FIX_VEC;
        nAcc     = 0;
        nRes     = 0;
        outReady = 1'b1;
        dataIn   = blk[0];
        inValid  = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            acc = inReady[0] && inValid;
            tick();
            if (acc) begin
                if (nAcc < 3) accCyc[nAcc] = cyc;
                nAcc++;
                if (nAcc < 3) begin
                    dataIn = blk[nAcc];
                end else begin
                    inValid = 1'b0;
                    dataIn  = '0;
                end
            end
            if (outValid[0]) begin
                if (nRes < 3) check($sformatf("b2b.data.%0d", nRes), dataOut[0], blkExp[nRes]);
                nRes++;
            end
        end
        check("b2b.accepts", 128'(nAcc), 128'(3));
        check("b2b.validCycles", 128'(nRes), 128'(3));
        if (nAcc >= 3) begin
            check("b2b.spacing01", 128'(accCyc[1] - accCyc[0]), 128'(6));
            check("b2b.spacing12", 128'(accCyc[2] - accCyc[1]), 128'(6));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
